// File: rtl/dds_melody_seq_if.sv
// rtl/dds_melody_seq_if.sv - control/status bundle between upper control and the melody sequencer
//
// Purpose: groups the table-write port, playback controls and the note/status
// outputs of dds_melody_seq into one interface.
// Signals:
//   wr_en, wr_addr, wr_note, wr_dur : table write port (controller -> sequencer)
//   start, stop, loop               : playback controls (controller -> sequencer)
//   note_bin, note_valid            : note code and sounding flag (sequencer -> dds)
//   busy, done, step                : playback status (sequencer -> controller)
// Modports: master = controller side, slave = sequencer side.

interface dds_melody_seq_if #(
    parameter int SEQ_LEN = 8
);
    localparam int AW = $clog2(SEQ_LEN);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_note;
    logic [3:0]    wr_dur;
    logic          start;
    logic          stop;
    logic          loop;
    logic [2:0]    note_bin;
    logic          note_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] step;

    modport master (
        output wr_en, wr_addr, wr_note, wr_dur, start, stop, loop,
        input  note_bin, note_valid, busy, done, step
    );

    modport slave (
        input  wr_en, wr_addr, wr_note, wr_dur, start, stop, loop,
        output note_bin, note_valid, busy, done, step
    );
endinterface

// File: rtl/dds_melody_seq.sv
// rtl/dds_melody_seq.sv - melody sequencer feeding note codes to the dds tone generator
//
// Purpose: plays a table of SEQ_LEN (note, duration) entries. Each note is held
// for dur beat ticks of TICK_DIV clk cycles. A duration of 0 marks end of melody.
// Supports start/stop, optional looping and a one-cycle done pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : dds_melody_seq_if.slave (table write, start/stop/loop, note/status outputs)
// Configuration macro: DDS_SEQ_GAP_EN - when defined, a muted GAP of GAP_TICKS
//   ticks follows every note; when undefined notes are legato with a 1-cycle
//   fetch bubble and GAP_TICKS is not used.

module dds_melody_seq #(
    parameter int TICK_DIV  = 1000,
    parameter int SEQ_LEN   = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dds_melody_seq_if.slave       bus
);
    localparam int AW = $clog2(SEQ_LEN);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] STEP_LAST = AW'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
`ifdef DDS_SEQ_GAP_EN
        S_GAP,
`endif
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [3:0]    remaining;
    logic [AW-1:0] step_q;
    logic [2:0]    note_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    // Table storage is not reset; contents are undefined until written.
    logic [6:0]    table_q [SEQ_LEN];
    logic [6:0]    entry;
    logic [2:0]    entry_note;
    logic [3:0]    entry_dur;

    logic          tick;
    logic          advance;
    logic          fetch_zero;
    logic          at_end;
    logic          restart;
    logic          finish;

`ifdef DDS_SEQ_GAP_EN
    localparam logic [15:0] GAP_INIT = 16'(GAP_TICKS);
    logic [15:0]   gap_cnt;
`endif

    assign entry      = table_q[step_q];
    assign entry_note = entry[6:4];
    assign entry_dur  = entry[3:0];

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.wr_en) begin
            table_q[bus.wr_addr] <= {bus.wr_note, bus.wr_dur};
        end
    end

    // Segment bookkeeping: "advance" fires on the last tick of the segment
    // that ends a note (PLAY when legato, GAP otherwise). "at_end" is the END
    // decision, which takes no cycle of its own.
    always_comb begin
        tick       = (tick_cnt == TICK_LAST);
`ifdef DDS_SEQ_GAP_EN
        advance    = (state == S_GAP) && tick && (gap_cnt == 16'd1);
`else
        advance    = (state == S_PLAY) && tick && (remaining == 4'd1);
`endif
        fetch_zero = (state == S_FETCH) && (entry_dur == 4'd0);
        at_end     = fetch_zero || (advance && step_q == STEP_LAST);
        // An empty entry 0 would spin forever when looping, so it always finishes.
        restart    = at_end && bus.loop && (step_q != '0);
        finish     = at_end && !restart;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            remaining <= '0;
            step_q    <= '0;
            note_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DDS_SEQ_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.stop && state != S_IDLE) begin
                state    <= S_IDLE;
                note_q   <= '0;
                valid_q  <= 1'b0;
                busy_q   <= 1'b0;
                step_q   <= '0;
                tick_cnt <= '0;
            end else if (finish) begin
                state    <= S_DONE;
                valid_q  <= 1'b0;
                done_q   <= 1'b1;
            end else if (restart) begin
                state    <= S_FETCH;
                step_q   <= '0;
                valid_q  <= 1'b0;
                tick_cnt <= '0;
            end else if (advance) begin
                state    <= S_FETCH;
                step_q   <= step_q + 1'b1;
                valid_q  <= 1'b0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            state    <= S_FETCH;
                            step_q   <= '0;
                            busy_q   <= 1'b1;
                            tick_cnt <= '0;
                        end
                    end
                    S_FETCH: begin
                        // dur==0 is taken by the END decision above.
                        state     <= S_PLAY;
                        note_q    <= entry_note;
                        valid_q   <= 1'b1;
                        remaining <= entry_dur;
                        tick_cnt  <= '0;
                    end
                    S_PLAY: begin
                        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                        if (tick) begin
                            remaining <= remaining - 1'b1;
`ifdef DDS_SEQ_GAP_EN
                            if (remaining == 4'd1) begin
                                state   <= S_GAP;
                                valid_q <= 1'b0;
                                gap_cnt <= GAP_INIT;
                            end
`endif
                        end
                    end
`ifdef DDS_SEQ_GAP_EN
                    S_GAP: begin
                        // Tick phase carries over from PLAY without clearing.
                        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                        if (tick) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
`endif
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.note_bin   = note_q;
    assign bus.note_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.step       = step_q;
endmodule
